utopia_tx_scheduler: RTL and testbench
======================================

// Module: utopia_tx_scheduler
// PURPOSE
//  Round-robin cell scheduler for NumTx Utopia transmit ports sharing one cell-transfer datapath.
//  Per port: picks a cell only when the port has a cell queued (req) and the PHY reports space (clav).
//  Sequences the 53-byte transfer: soc, en, byte index, port select. Returns a per-port ack at end of cell.
//  Sits between the per-port cell queues and the CoreTransmit-side datapath mux. Controller only; no cell data passes through it.
// PARAMETERS
//  NumTx      4    number of transmit ports (>=2)
//  CellBytes  53   bytes per ATM cell at IfWidth=8
//  CntW       16   width of sent-cell counter
// PORTS
//  clk_in      in   1               single clock; all state on posedge
//  reset       in   1               asynchronous, active-low; clears all state
//  port_en     in   NumTx           per-port enable mask; disabled ports never granted
//  req         in   NumTx           port has a complete cell queued
//  clav        in   NumTx           PHY cell-available, one per port
//  sel         out  $clog2(NumTx)   index of granted port (datapath mux select)
//  grant       out  NumTx           one-hot grant; all-zero when idle
//  byte_idx    out  $clog2(CellBytes)  index into ATMcell.Mem for current byte
//  soc         out  1               start of cell, high with byte 0 only
//  en          out  1               transfer enable, high for every cell byte
//  ack         out  NumTx           one-cycle pulse to granted port on last byte
//  busy        out  1               high in XFER and GAP
//  cell_count  out  CntW            total cells completed, wraps to 0
// BEHAVIOUR
//  Reset (async, while reset==0): state=IDLE, grant=0, sel=0, byte_idx=0, soc=0, en=0, ack=0,
//   busy=0, cell_count=0, ptr=NumTx-1, so port 0 has first priority. Reset mid-cell aborts with no ack.
//  eligible = req & clav & port_en. It is evaluated in IDLE only.
//  IDLE: if eligible!=0, winner = first set bit scanning ptr+1, ptr+2 .. wrapping mod NumTx.
//   Register sel/grant and go XFER. Next cycle: soc=1, en=1, byte_idx=0.
//   Latency: eligible seen at edge k gives soc at the output from edge k+1 to k+2.
//  XFER: en=1 every cycle. byte_idx increments by 1 per cycle. soc=1 only when byte_idx==0.
//   At byte_idx==CellBytes-1: ack[sel]=1 this cycle, ptr<=sel, cell_count+=1 (mod 2^CntW), go GAP.
//   req/clav/port_en changes during XFER are ignored. A started cell always completes.
//  GAP: one cycle with en=0, soc=0, ack=0, grant held, busy=1; then IDLE with grant cleared.
//   Spacing: back-to-back cells occupy 1 IDLE + CellBytes XFER + 1 GAP = 55 cycles.
//  Fairness: the last served port gets lowest priority. A lone eligible port is granted every slot.
//   ptr wraps NumTx-1 -> 0.
//  Simultaneous eligibility: only one grant, per rotating priority. The others wait with no loss.
//  Outputs are registered; none combinational from inputs.
// STRUCTURE
//  Shared definitions package: sched_state_t enum {IDLE,XFER,GAP}; CELL_BYTES=53 constant.
//  Sub-module rr_pick #(N): combinational; inputs eligible and ptr; outputs winner index and found.
//   One instance inside this block.
// TESTING
//  1 Reset, then req=0001,clav=0001 -> soc 1 cycle later, en high 53 cycles, byte_idx 0..52,
//    ack[0] on byte 52, cell_count=1.
//  2 req=clav=1111 held for 8 cells -> grant order 0,1,2,3,0,1,2,3; each cell spacing 55 cycles.
//  3 Drop clav[sel] and req[sel] at byte 20 -> transfer completes unchanged, ack still issued.
//  4 port_en=1101, req=clav=1111 -> port 1 never granted; order 0,2,3,0.
//  5 Assert reset at byte 30 -> en/soc/grant drop immediately, no ack.
//    After release, ptr=3 and port 0 is granted first.
//  6 Preload cell_count by running 2^CntW cells (CntW=4 in bench) -> wraps to 0 without glitching grant.

Source files
------------

// File: rtl/utopia_tx_scheduler_pkg.sv
// Shared definitions for the Utopia TX cell scheduler: FSM state encoding and cell geometry.
package utopia_tx_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } sched_state_t;

    localparam int CELL_BYTES = 53;

endpackage

// File: rtl/utopia_tx_scheduler_if.sv
// Handshake between the per-port cell queues/PHY status and the scheduler's datapath control outputs.
interface utopia_tx_scheduler_if
    import utopia_tx_scheduler_pkg::*;
#(
    parameter int NumTx     = 4,
    parameter int CellBytes = CELL_BYTES,
    parameter int CntW      = 16
);
    localparam int SelW  = $clog2(NumTx);
    localparam int ByteW = $clog2(CellBytes);

    logic [NumTx-1:0] port_en;
    logic [NumTx-1:0] req;
    logic [NumTx-1:0] clav;
    logic [SelW-1:0]  sel;
    logic [NumTx-1:0] grant;
    logic [ByteW-1:0] byte_idx;
    logic             soc;
    logic             en;
    logic [NumTx-1:0] ack;
    logic             busy;
    logic [CntW-1:0]  cell_count;

    modport master (
        input  port_en, req, clav,
        output sel, grant, byte_idx, soc, en, ack, busy, cell_count
    );

    modport slave (
        output port_en, req, clav,
        input  sel, grant, byte_idx, soc, en, ack, busy, cell_count
    );

endinterface

// File: rtl/utopia_tx_scheduler_rr_pick.sv
// Rotating-priority picker: first set bit of i_eligible scanning from i_ptr+1 upward, wrapping mod N.
module rr_pick #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] i_eligible,
    input  logic [W-1:0] i_ptr,
    output logic [W-1:0] o_winner,
    output logic         o_found
);

    always_comb begin
        logic [W-1:0] w_idx;
        w_idx    = '0;
        o_found  = 1'b0;
        o_winner = '0;
        // i runs to N so the last-served port is still reachable when it is the only one eligible
        for (int i = 1; i <= N; i++) begin
            w_idx = W'((int'(i_ptr) + i) % N);
            if (!o_found && i_eligible[w_idx]) begin
                o_found  = 1'b1;
                o_winner = w_idx;
            end
        end
    end

endmodule

// File: rtl/utopia_tx_scheduler.sv
// Round-robin Utopia TX cell scheduler; all outputs are registered copies of the state decode (one cycle behind state).
// state | meaning -- IDLE | arbitrate eligible ports ; XFER | one cell byte per cycle ; GAP | dead cycle, grant held
module utopia_tx_scheduler
    import utopia_tx_scheduler_pkg::*;
#(
    parameter int NumTx     = 4,
    parameter int CellBytes = CELL_BYTES,
    parameter int CntW      = 16
) (
    input logic                    clk_in,
    input logic                    reset,
    utopia_tx_scheduler_if.master  bus
);

    localparam int SelW  = $clog2(NumTx);
    localparam int ByteW = $clog2(CellBytes);
    localparam logic [ByteW-1:0] LastByte = ByteW'(CellBytes - 1);
    localparam logic [SelW-1:0]  PtrInit  = SelW'(NumTx - 1);

    sched_state_t     r_state;
    sched_state_t     w_state_nxt;
    logic [ByteW-1:0] r_byte;
    logic [ByteW-1:0] w_byte_nxt;
    logic [SelW-1:0]  r_sel;
    logic [SelW-1:0]  w_sel_nxt;
    logic [SelW-1:0]  r_ptr;
    logic [SelW-1:0]  w_ptr_nxt;
    logic [CntW-1:0]  r_cnt;
    logic [CntW-1:0]  w_cnt_nxt;

    logic [NumTx-1:0] w_eligible;
    logic [SelW-1:0]  w_winner;
    logic             w_found;

    logic [NumTx-1:0] w_onehot;
    logic [NumTx-1:0] w_grant;
    logic [NumTx-1:0] w_ack;
    logic             w_soc;
    logic             w_en;
    logic             w_busy;

    logic [SelW-1:0]  r_sel_out;
    logic [NumTx-1:0] r_grant_out;
    logic [ByteW-1:0] r_byte_out;
    logic             r_soc_out;
    logic             r_en_out;
    logic [NumTx-1:0] r_ack_out;
    logic             r_busy_out;
    logic [CntW-1:0]  r_cnt_out;

    assign w_eligible = bus.req & bus.clav & bus.port_en;

    rr_pick #(
        .N (NumTx),
        .W (SelW)
    ) u_rr_pick (
        .i_eligible (w_eligible),
        .i_ptr      (r_ptr),
        .o_winner   (w_winner),
        .o_found    (w_found)
    );

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_byte  <= '0;
            r_sel   <= '0;
            r_ptr   <= PtrInit;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_byte  <= w_byte_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Inputs are looked at only in IDLE, so a started cell always runs to completion.
    always_comb begin
        w_state_nxt = r_state;
        w_byte_nxt  = r_byte;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = XFER;
                    w_sel_nxt   = w_winner;
                    w_byte_nxt  = '0;
                end
            end
            XFER: begin
                if (r_byte == LastByte) begin
                    w_state_nxt = GAP;
                    w_ptr_nxt   = r_sel;
                    w_cnt_nxt   = r_cnt + CntW'(1);
                    w_byte_nxt  = '0;
                end else begin
                    w_byte_nxt  = r_byte + ByteW'(1);
                end
            end
            GAP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        w_onehot = '0;
        w_onehot[r_sel] = 1'b1;
        w_grant  = '0;
        w_ack    = '0;
        w_soc    = 1'b0;
        w_en     = 1'b0;
        w_busy   = 1'b0;
        case (r_state)
            XFER: begin
                w_grant = w_onehot;
                w_en    = 1'b1;
                w_busy  = 1'b1;
                w_soc   = (r_byte == '0);
                w_ack   = (r_byte == LastByte) ? w_onehot : '0;
            end
            GAP: begin
                w_grant = w_onehot;
                w_busy  = 1'b1;
            end
            default: begin
                w_grant = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_sel_out   <= '0;
            r_grant_out <= '0;
            r_byte_out  <= '0;
            r_soc_out   <= 1'b0;
            r_en_out    <= 1'b0;
            r_ack_out   <= '0;
            r_busy_out  <= 1'b0;
            r_cnt_out   <= '0;
        end else begin
            r_sel_out   <= r_sel;
            r_grant_out <= w_grant;
            r_byte_out  <= r_byte;
            r_soc_out   <= w_soc;
            r_en_out    <= w_en;
            r_ack_out   <= w_ack;
            r_busy_out  <= w_busy;
            r_cnt_out   <= r_cnt;
        end
    end

    assign bus.sel        = r_sel_out;
    assign bus.grant      = r_grant_out;
    assign bus.byte_idx   = r_byte_out;
    assign bus.soc        = r_soc_out;
    assign bus.en         = r_en_out;
    assign bus.ack        = r_ack_out;
    assign bus.busy       = r_busy_out;
    assign bus.cell_count = r_cnt_out;

endmodule

// File: tb/tb_utopia_tx_scheduler.sv
// Self-checking bench: cell-timeline reference model plus directed scenarios and a randomized run.
module tb_utopia_tx_scheduler;

    localparam int NT = 4;
    localparam int CB = 53;
    localparam int CW = 4;

    logic clk_in = 1'b0;
    logic reset  = 1'b1;

    always #5 clk_in = ~clk_in;

    utopia_tx_scheduler_if #(.NumTx(NT), .CellBytes(CB), .CntW(CW)) bus ();

    utopia_tx_scheduler #(.NumTx(NT), .CellBytes(CB), .CntW(CW)) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int en_total = 0;
    bit chk_on   = 1'b0;

    int soc_port[$];
    int soc_cyc[$];
    int ack_port[$];

    // Reference model: a cell is a timeline counted in cycles since the arbitration edge.
    // Offset 1..53 carry bytes 0..52, offset 54 is the dead cycle, and arbitration may happen again after it.
    bit m_cell;
    int m_o;
    int m_port;
    int m_ptr;
    int m_cnt;

    function automatic int onehot_idx(logic [NT-1:0] g);
        logic [NT-1:0] one;
        for (int i = 0; i < NT; i++) begin
            one = '0;
            one[i] = 1'b1;
            if (g === one) return i;
        end
        return -1;
    endfunction

    function void chk_eq(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(posedge clk_in or negedge reset) begin : model
        logic [NT-1:0] elig;
        bit found;
        int p;
        if (!reset) begin
            m_cell = 1'b0;
            m_o    = 0;
            m_port = 0;
            m_ptr  = NT - 1;
            m_cnt  = 0;
        end else if (m_cell && m_o < 54) begin
            m_o++;
            if (m_o == 54) m_cnt = (m_cnt + 1) % (1 << CW);
        end else begin
            m_cell = 1'b0;
            elig   = bus.req & bus.clav & bus.port_en;
            found  = 1'b0;
            for (int i = 1; i <= NT; i++) begin
                p = (m_ptr + i) % NT;
                if (!found && elig[p]) begin
                    found  = 1'b1;
                    m_port = p;
                end
            end
            if (found) begin
                m_ptr  = m_port;
                m_cell = 1'b1;
                m_o    = 0;
            end
        end
    end

    always @(negedge clk_in) begin : compare
        logic [NT-1:0] oh;
        logic [NT-1:0] e_grant;
        logic [NT-1:0] e_ack;
        bit e_busy;
        bit e_en;
        bit e_soc;
        cyc++;
        if (chk_on) begin
            oh = '0;
            oh[m_port] = 1'b1;
            e_busy  = m_cell && m_o >= 1;
            e_en    = m_cell && m_o >= 1 && m_o <= 53;
            e_soc   = m_cell && m_o == 1;
            e_grant = e_busy ? oh : '0;
            e_ack   = (m_cell && m_o == 53) ? oh : '0;
            chk_eq("grant", 32'(bus.grant), 32'(e_grant));
            chk_eq("busy", 32'(bus.busy), 32'(e_busy));
            chk_eq("en", 32'(bus.en), 32'(e_en));
            chk_eq("soc", 32'(bus.soc), 32'(e_soc));
            chk_eq("ack", 32'(bus.ack), 32'(e_ack));
            chk_eq("cell_count", 32'(bus.cell_count), 32'(m_cnt));
            if (e_busy) chk_eq("sel", 32'(bus.sel), 32'(m_port));
            if (e_en) chk_eq("byte_idx", 32'(bus.byte_idx), 32'(m_o - 1));
        end
        if (bus.soc === 1'b1) begin
            soc_port.push_back(onehot_idx(bus.grant));
            soc_cyc.push_back(cyc);
        end
        if (bus.ack !== '0) ack_port.push_back(onehot_idx(bus.ack));
        if (bus.en === 1'b1) en_total++;
    end

    task automatic tick(int n);
        repeat (n) begin
            @(negedge clk_in);
            #1;
        end
    endtask

    task automatic wait_socs(string name, int target, int budget);
        int b = 0;
        while (soc_port.size() < target && b < budget) begin
            tick(1);
            b++;
        end
        checks++;
        if (soc_port.size() < target) begin
            failures++;
            $display("FAIL %s: saw %0d cells, required %0d within %0d cycles", name, soc_port.size(), target, budget);
        end
    endtask

    task automatic wait_byte(string name, int idx, int budget);
        int b = 0;
        while (!(bus.en === 1'b1 && int'(bus.byte_idx) == idx) && b < budget) begin
            tick(1);
            b++;
        end
        checks++;
        if (b >= budget) begin
            failures++;
            $display("FAIL %s: byte %0d not reached within %0d cycles", name, idx, budget);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(1);
    endtask

    task automatic set_inputs(logic [NT-1:0] r, logic [NT-1:0] c, logic [NT-1:0] e);
        bus.req     = r;
        bus.clav    = c;
        bus.port_en = e;
    endtask

    initial begin : stimulus
        int base;
        int ackb;
        int enb;
        int c0;
        int s;
        logic [NT-1:0] tmp;
        int exp4[4];

        set_inputs('0, '0, '1);
        #1 reset = 1'b0;
        #1 chk_on = 1'b1;
        tick(3);
        chk_eq("rst_grant", 32'(bus.grant), 32'd0);
        chk_eq("rst_count", 32'(bus.cell_count), 32'd0);
        reset = 1'b1;
        tick(2);

        // single cell on port 0
        base = soc_port.size();
        ackb = ack_port.size();
        enb  = en_total;
        c0   = cyc;
        set_inputs(4'b0001, 4'b0001, '1);
        wait_socs("t1_soc", base + 1, 10);
        set_inputs('0, '0, '1);
        if (soc_port.size() > base) begin
            chk_eq("t1_latency", 32'(soc_cyc[base] - c0), 32'd2);
            chk_eq("t1_port", 32'(soc_port[base]), 32'd0);
        end
        tick(60);
        chk_eq("t1_en_cycles", 32'(en_total - enb), 32'd53);
        chk_eq("t1_acks", 32'(ack_port.size() - ackb), 32'd1);
        if (ack_port.size() > ackb) chk_eq("t1_ack_port", 32'(ack_port[ackb]), 32'd0);
        chk_eq("t1_count", 32'(bus.cell_count), 32'd1);

        // all ports busy: rotation continues from port 0 served last
        base = soc_port.size();
        set_inputs('1, '1, '1);
        wait_socs("t2_soc", base + 8, 8 * 55 + 20);
        set_inputs('0, '0, '1);
        if (soc_port.size() >= base + 8) begin
            for (int i = 0; i < 8; i++) chk_eq("t2_order", 32'(soc_port[base + i]), 32'((1 + i) % NT));
            for (int i = 0; i < 7; i++) chk_eq("t2_spacing", 32'(soc_cyc[base + i + 1] - soc_cyc[base + i]), 32'd55);
        end
        tick(60);

        // withdraw req/clav of the port in flight at byte 20
        set_inputs('1, '1, '1);
        wait_byte("t3_byte20", 20, 200);
        s    = onehot_idx(bus.grant);
        ackb = ack_port.size();
        if (s >= 0) begin
            tmp = bus.req;  tmp[s] = 1'b0; bus.req  = tmp;
            tmp = bus.clav; tmp[s] = 1'b0; bus.clav = tmp;
        end
        tick(40);
        chk_eq("t3_acks", 32'(ack_port.size() > ackb), 32'd1);
        if (ack_port.size() > ackb) chk_eq("t3_ack_port", 32'(ack_port[ackb]), 32'(s));
        set_inputs('0, '0, '1);
        tick(120);

        // port 1 masked off
        do_reset();
        base = soc_port.size();
        set_inputs('1, '1, 4'b1101);
        wait_socs("t4_soc", base + 4, 4 * 55 + 20);
        set_inputs('0, '0, 4'b1101);
        exp4 = '{0, 2, 3, 0};
        if (soc_port.size() >= base + 4)
            for (int i = 0; i < 4; i++) chk_eq("t4_order", 32'(soc_port[base + i]), 32'(exp4[i]));
        tick(120);

        // reset in the middle of a cell
        set_inputs('1, '1, '1);
        wait_byte("t5_byte30", 30, 300);
        ackb = ack_port.size();
        #2 reset = 1'b0;
        #1;
        chk_eq("t5_grant_drop", 32'(bus.grant), 32'd0);
        chk_eq("t5_en_drop", 32'(bus.en), 32'd0);
        chk_eq("t5_soc_drop", 32'(bus.soc), 32'd0);
        tick(3);
        chk_eq("t5_no_ack", 32'(ack_port.size() - ackb), 32'd0);
        base = soc_port.size();
        reset = 1'b1;
        wait_socs("t5_soc", base + 1, 10);
        if (soc_port.size() > base) chk_eq("t5_first_port", 32'(soc_port[base]), 32'd0);
        set_inputs('0, '0, '1);
        tick(60);

        // randomized traffic, checked by the model every cycle
        for (int i = 0; i < 1500; i++) begin
            set_inputs(NT'($urandom), NT'($urandom), NT'($urandom | $urandom));
            tick(1);
        end
        set_inputs('0, '0, '1);
        tick(120);

        // lone port for 2^CW cells: count wraps to zero
        do_reset();
        base = soc_port.size();
        ackb = ack_port.size();
        set_inputs(4'b0001, 4'b0001, '1);
        wait_socs("t6_soc", base + (1 << CW), (1 << CW) * 55 + 30);
        set_inputs('0, '0, '1);
        tick(60);
        chk_eq("t6_acks", 32'(ack_port.size() - ackb), 32'(1 << CW));
        chk_eq("t6_wrap", 32'(bus.cell_count), 32'd0);
        if (soc_port.size() >= base + 2)
            chk_eq("t6_spacing", 32'(soc_cyc[base + 1] - soc_cyc[base]), 32'd55);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
